// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - Access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD, SZ_ILL is rejected).
//   - Requester identifiers (PORT_A = pipeline LSU, PORT_B = debug/loader).
//   - calc_be_err: lane enables plus the error flag for one access.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic [3:0] be;
        logic       err;
    } be_err_t;

    // Byte enables for an access and whether it must be rejected.
    // limit is the first out-of-range byte address.
    function automatic be_err_t calc_be_err(input logic [1:0]  size,
                                            input logic [31:0] addr,
                                            input logic [31:0] limit);
        be_err_t r;
        r.be  = 4'b0000;
        r.err = 1'b0;
        case (size)
            SZ_BYTE: r.be = 4'b0001 << addr[1:0];
            SZ_HALF: begin
                r.be  = addr[1] ? 4'b1100 : 4'b0011;
                r.err = addr[0];
            end
            SZ_WORD: begin
                r.be  = 4'b1111;
                r.err = |addr[1:0];
            end
            default: r.err = 1'b1;
        endcase
        if (addr >= limit) begin
            r.err = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/half/word lane out of a bank
// read word and sign- or zero-extends it to 32 bits. Purely combinational.
//   word_i     in  32  raw word from the bank
//   offset_i   in  2   byte offset of the access (addr[1:0])
//   size_i     in  2   access size encoding
//   unsigned_i in  1   1 = zero-extend, 0 = sign-extend
//   data_o     out 32  right-justified, extended load data
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{offset_i, 3'b000} +: 8];
        half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory bank between
// port A (pipeline load/store unit) and port B (debug/program loader).
// Every accepted request gets exactly one response pulse one cycle later.
//   clk, rst                 clock, synchronous active-high reset
//   {a,b}_req/_we/_addr/_wdata/_size/_unsigned   request fields (held until gnt)
//   {a,b}_gnt                combinational accept for the coming edge
//   {a,b}_rvalid/_rdata/_err response, one cycle after the grant
//   mem_*                    bank controls; all zero when idle or on error
//   mem_read_data            bank read word, valid the cycle after mem_read_en
//
// Handshake: a request is consumed at the rising edge where req && gnt;
// its response appears as a single-cycle rvalid in the following cycle,
// with rdata/err forced to 0 whenever rvalid is low.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [1:0]  a_size,
    input  logic        a_unsigned,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [1:0]  b_size,
    input  logic        b_unsigned,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,

    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    // Arbitration history and the single in-flight response slot.
    port_e       last_q,     last_d;
    logic        rsp_vld_q,  rsp_vld_d;
    port_e       rsp_port_q, rsp_port_d;
    logic        rsp_load_q, rsp_load_d;
    logic        rsp_err_q,  rsp_err_d;
    logic [1:0]  rsp_off_q,  rsp_off_d;
    logic [1:0]  rsp_size_q, rsp_size_d;
    logic        rsp_uns_q,  rsp_uns_d;

    logic        a_sel, b_sel, any_gnt, access;
    logic        sel_we, sel_uns;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size;
    be_err_t     chk;
    logic [31:0] aligned;
    logic [31:0] rsp_data;
    logic        rsp_live;

    // Grant selection and bank drive for the current cycle.
    always_comb begin
        // On contention the port that did not win last time goes first.
        a_sel = a_req & (~b_req | (last_q == PORT_B)) & ~rst;
        b_sel = b_req & (~a_req | (last_q == PORT_A)) & ~rst;
        any_gnt = a_sel | b_sel;

        sel_we    = b_sel ? b_we       : a_we;
        sel_addr  = b_sel ? b_addr     : a_addr;
        sel_wdata = b_sel ? b_wdata    : a_wdata;
        sel_size  = b_sel ? b_size     : a_size;
        sel_uns   = b_sel ? b_unsigned : a_unsigned;

        chk    = calc_be_err(sel_size, sel_addr, ADDR_LIMIT);
        // Rejected accesses are consumed but never reach the bank.
        access = any_gnt & ~chk.err;

        mem_read_en     = access & ~sel_we;
        mem_write_en    = access & sel_we;
        mem_address     = access ? sel_addr : 32'd0;
        mem_write_data  = (access & sel_we) ? sel_wdata : 32'd0;
        mem_byte_enable = access ? chk.be : 4'b0000;

        a_gnt = a_sel;
        b_gnt = b_sel;

        last_d = last_q;
        if (a_sel) begin
            last_d = PORT_A;
        end else if (b_sel) begin
            last_d = PORT_B;
        end

        rsp_vld_d  = any_gnt;
        rsp_port_d = b_sel ? PORT_B : PORT_A;
        rsp_load_d = ~sel_we;
        rsp_err_d  = chk.err;
        rsp_off_d  = sel_addr[1:0];
        rsp_size_d = sel_size;
        rsp_uns_d  = sel_uns;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= PORT_B;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= PORT_A;
            rsp_load_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_off_q  <= 2'b00;
            rsp_size_q <= 2'b00;
            rsp_uns_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
            rsp_load_q <= rsp_load_d;
            rsp_err_q  <= rsp_err_d;
            rsp_off_q  <= rsp_off_d;
            rsp_size_q <= rsp_size_d;
            rsp_uns_q  <= rsp_uns_d;
        end
    end

    dmem_load_align u_align (
        .word_i     (mem_read_data),
        .offset_i   (rsp_off_q),
        .size_i     (rsp_size_q),
        .unsigned_i (rsp_uns_q),
        .data_o     (aligned)
    );

    // A response captured just before reset asserts must not escape while
    // rst is high, so the slot is masked combinationally as well as cleared.
    always_comb begin
        rsp_live = rsp_vld_q & ~rst;
        rsp_data = (rsp_load_q & ~rsp_err_q) ? aligned : 32'd0;

        a_rvalid = rsp_live & (rsp_port_q == PORT_A);
        b_rvalid = rsp_live & (rsp_port_q == PORT_B);
        a_rdata  = a_rvalid ? rsp_data : 32'd0;
        b_rdata  = b_rvalid ? rsp_data : 32'd0;
        a_err    = a_rvalid & rsp_err_q;
        b_err    = b_rvalid & rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single-port accesses followed by
// hand-written reset and contention sequences, with a behavioural bank.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, a_unsigned, a_gnt, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_size;
    logic        b_req, b_we, b_unsigned, b_gnt, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_size;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_enable;

    int checks   = 0;
    int failures = 0;

    // {port, err, rdata} of responses still owed
    logic [33:0] exp_q[$];

    dmem_arbiter #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_size(a_size), .a_unsigned(a_unsigned), .a_gnt(a_gnt),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_size(b_size), .b_unsigned(b_unsigned), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_enable(mem_byte_enable), .mem_read_data(mem_read_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bank model ----------------
    // Cleared on reset with word 0 preloaded to 0x0000000F. Write data is
    // right-justified and moved into place starting at the lowest enabled lane.
    logic [31:0] mem [0:1023];
    logic [31:0] wr_shifted;
    int          wr_sh;

    always @(posedge clk) begin
        if (rst) begin
            mem_read_data <= 32'd0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h0000000F;
        end else begin
            if (mem_read_en) mem_read_data <= mem[mem_address[11:2]];
            if (mem_write_en) begin
                wr_sh = mem_byte_enable[0] ? 0 : mem_byte_enable[1] ? 1 :
                        mem_byte_enable[2] ? 2 : 3;
                wr_shifted = mem_write_data << (8 * wr_sh);
                for (int l = 0; l < 4; l++)
                    if (mem_byte_enable[l]) mem[mem_address[11:2]][8*l +: 8] <= wr_shifted[8*l +: 8];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        if (!port) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_size = size; a_unsigned = uns;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_size = size; b_unsigned = uns;
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_size = 2'b10; a_unsigned = 1'b0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_size = 2'b10; b_unsigned = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        port;   // 0 = A, 1 = B
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [3:0]  be;     // expected bank lanes (0 when rejected)
        logic [31:0] mwdata; // expected mem_write_data
        logic [31:0] rdata;  // expected response data
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(logic port, logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [1:0] size, logic uns, logic [3:0] be,
                                logic [31:0] mwdata, logic [31:0] rdata, logic err);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.uns = uns; v.be = be; v.mwdata = mwdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    logic [31:0] ctn_data;
    logic        ctn_port;
    logic [33:0] e;

    initial begin
        //           port we addr          wdata         sz    u  be       mwdata        rdata         err
        vecs[0]  = mk(0, 0, 32'h0000_0000, 32'h0,        2'b10, 0, 4'b1111, 32'h0,        32'h0000000F, 0);
        vecs[1]  = mk(0, 1, 32'h0000_0005, 32'h00000080, 2'b00, 0, 4'b0010, 32'h00000080, 32'h0,        0);
        vecs[2]  = mk(0, 0, 32'h0000_0005, 32'h0,        2'b00, 0, 4'b0010, 32'h0,        32'hFFFFFF80, 0);
        vecs[3]  = mk(0, 0, 32'h0000_0005, 32'h0,        2'b00, 1, 4'b0010, 32'h0,        32'h00000080, 0);
        vecs[4]  = mk(0, 0, 32'h0000_0004, 32'h0,        2'b10, 0, 4'b1111, 32'h0,        32'h00008000, 0);
        vecs[5]  = mk(0, 0, 32'h0000_0003, 32'h0,        2'b01, 0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[6]  = mk(1, 1, 32'h0000_1000, 32'h12345678, 2'b10, 0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[7]  = mk(0, 1, 32'h0000_0002, 32'h0000BEEF, 2'b01, 0, 4'b1100, 32'h0000BEEF, 32'h0,        0);
        vecs[8]  = mk(0, 0, 32'h0000_0000, 32'h0,        2'b10, 0, 4'b1111, 32'h0,        32'hBEEF000F, 0);
        vecs[9]  = mk(0, 0, 32'h0000_0002, 32'h0,        2'b01, 0, 4'b1100, 32'h0,        32'hFFFFBEEF, 0);
        vecs[10] = mk(1, 0, 32'h0000_0002, 32'h0,        2'b01, 1, 4'b1100, 32'h0,        32'h0000BEEF, 0);
        vecs[11] = mk(0, 0, 32'h0000_0000, 32'h0,        2'b11, 0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[12] = mk(1, 0, 32'h0000_0002, 32'h0,        2'b00, 0, 4'b0100, 32'h0,        32'hFFFFFFEF, 0);
        vecs[13] = mk(1, 0, 32'h0000_0FFC, 32'h0,        2'b10, 0, 4'b1111, 32'h0,        32'h0,        0);
        vecs[14] = mk(0, 0, 32'h0000_1004, 32'h0,        2'b10, 0, 4'b0000, 32'h0,        32'h0,        1);

        // ---- reset state, requests held high to show no grant under reset ----
        idle();
        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 2'b10, 0);
        drive(1, 0, 32'h4, 32'h0, 2'b10, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        check("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("rst_rdata_or", a_rdata | b_rdata, 32'd0);
        check("rst_err", {30'd0, a_err, b_err}, 32'd0);
        check("rst_mem_ctl", {27'd0, mem_read_en, mem_write_en, mem_byte_enable == 4'b0000 ? 1'b0 : 1'b1, 2'b00}, 32'd0);
        check("rst_mem_addr", mem_address | mem_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // ---- table: one access per vector, response checked next cycle ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns);
            #1;
            check($sformatf("v%0d_gnt", i), {30'd0, a_gnt, b_gnt}, vecs[i].port ? 32'd1 : 32'd2);
            check($sformatf("v%0d_rd_en", i), {31'd0, mem_read_en}, {31'd0, ~vecs[i].err & ~vecs[i].we});
            check($sformatf("v%0d_wr_en", i), {31'd0, mem_write_en}, {31'd0, ~vecs[i].err & vecs[i].we});
            check($sformatf("v%0d_be", i), {28'd0, mem_byte_enable}, {28'd0, vecs[i].be});
            check($sformatf("v%0d_mwdata", i), mem_write_data, vecs[i].mwdata);
            check($sformatf("v%0d_maddr", i), mem_address, vecs[i].err ? 32'd0 : vecs[i].addr);
            @(negedge clk);
            idle();
            #1;
            check($sformatf("v%0d_rvalid", i), {30'd0, a_rvalid, b_rvalid}, vecs[i].port ? 32'd1 : 32'd2);
            check($sformatf("v%0d_rdata", i), vecs[i].port ? b_rdata : a_rdata, vecs[i].rdata);
            check($sformatf("v%0d_err", i), {31'd0, vecs[i].port ? b_err : a_err}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_idle_rdata", i), vecs[i].port ? a_rdata : b_rdata, 32'd0);
        end

        // ---- reset one cycle after a load grant: response must be dropped ----
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 2'b10, 0);
        #1;
        check("mid_gnt", {31'd0, a_gnt}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rvalid_in_rst", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("mid_rdata_in_rst", a_rdata, 32'd0);
        check("mid_gnt_in_rst", {31'd0, a_gnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("mid_rvalid_after", {30'd0, a_rvalid, b_rvalid}, 32'd0);

        // ---- contention: both ports request for 4 cycles, A wins first ----
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 2'b10, 0);
        drive(1, 0, 32'h4, 32'h0, 2'b10, 0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) idle();
            #1;
            check($sformatf("ctn%0d_one_rvalid", c), {31'd0, a_rvalid & b_rvalid}, 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("ctn%0d_rvalid", c), {30'd0, a_rvalid, b_rvalid}, e[33] ? 32'd1 : 32'd2);
                check($sformatf("ctn%0d_rdata", c), e[33] ? b_rdata : a_rdata, e[31:0]);
                check($sformatf("ctn%0d_err", c), {30'd0, a_err, b_err}, 32'd0);
            end else if (c > 0) begin
                check($sformatf("ctn%0d_no_rvalid", c), {30'd0, a_rvalid, b_rvalid}, 32'd0);
            end
            if (c < 4) begin
                ctn_port = c[0];
                ctn_data = ctn_port ? 32'h00000000 : 32'h0000000F;
                check($sformatf("ctn%0d_gnt", c), {30'd0, a_gnt, b_gnt}, ctn_port ? 32'd1 : 32'd2);
                exp_q.push_back({ctn_port, 1'b0, ctn_data});
            end else begin
                check($sformatf("ctn%0d_no_gnt", c), {30'd0, a_gnt, b_gnt}, 32'd0);
            end
        end
        check("ctn_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
